// File: rtl/decode.sv
// rtl/decode.sv - second CPU pipeline stage: assembles, splits and forwards instructions
//
// Purpose:
//   Consumes 16-bit instruction words from FETCH and assembles one- or
//   two-word instructions. Immediate-form instructions have
//   src_mode == 2'b11 and src_reg == 4'hF, and take a second word as the
//   immediate. DECODE splits each instruction into fields and holds them
//   for EXECUTE until they are accepted. After reset it sends a PC
//   redirect to FETCH.
//
// Configuration:
//   DECODE_JUMP_EN - when defined, an immediate jump (opcode 4'hF in
//   immediate form) is absorbed here and turned into a redirect to the
//   immediate. When undefined, it is forwarded like any other instruction.
//
// Parameters:
//   RESET_PC        - PC sent to FETCH after reset
//
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset
//   fe_valid_i      - FETCH word valid
//   fe_ready_o      - DECODE accepts the word
//   fe_addr_i       - address of the word
//   fe_inst_i       - instruction word
//   fe_valid_o      - single-cycle redirect pulse to FETCH
//   fe_pc_o         - redirect PC
//   exe_valid_o     - decoded instruction valid
//   exe_ready_i     - EXECUTE accepts
//   exe_addr_o      - address of the first instruction word
//   exe_opcode_o    - inst[15:12]
//   exe_src_reg_o   - inst[11:8]
//   exe_src_mode_o  - inst[7:6]
//   exe_dst_reg_o   - inst[5:2]
//   exe_dst_mode_o  - inst[1:0]
//   exe_imm_o       - second word, or 0 for single-word instructions
//   exe_imm_valid_o - exe_imm_o is meaningful
module decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fe_valid_i,
  output logic        fe_ready_o,
  input  logic [15:0] fe_addr_i,
  input  logic [15:0] fe_inst_i,
  output logic        fe_valid_o,
  output logic [15:0] fe_pc_o,
  output logic        exe_valid_o,
  input  logic        exe_ready_i,
  output logic [15:0] exe_addr_o,
  output logic [3:0]  exe_opcode_o,
  output logic [3:0]  exe_src_reg_o,
  output logic [1:0]  exe_src_mode_o,
  output logic [3:0]  exe_dst_reg_o,
  output logic [1:0]  exe_dst_mode_o,
  output logic [15:0] exe_imm_o,
  output logic        exe_imm_valid_o
);

  typedef enum logic [1:0] {
    S_REDIR = 2'd0,
    S_INST  = 2'd1,
    S_IMM   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        fe_ready_q, fe_ready_d;
  logic        fe_valid_q, fe_valid_d;
  logic [15:0] fe_pc_q, fe_pc_d;        // doubles as the redirect target
  logic [15:0] inst_q, inst_d;          // first word while waiting for the immediate
  logic [15:0] addr_q, addr_d;
  logic        exe_valid_q, exe_valid_d;
  logic [15:0] exe_addr_q, exe_addr_d;
  logic [15:0] exe_inst_q, exe_inst_d;
  logic [15:0] exe_imm_q, exe_imm_d;
  logic        exe_imm_valid_q, exe_imm_valid_d;

  logic consume;
  logic is_imm_form;

  // fe_ready_o is registered, so a word is only taken when the flop says so.
  assign consume     = fe_valid_i && fe_ready_q;
  assign is_imm_form = (fe_inst_i[7:6] == 2'b11) && (fe_inst_i[11:8] == 4'hF);

  always_comb begin
    state_d         = state_q;
    fe_pc_d         = fe_pc_q;
    inst_d          = inst_q;
    addr_d          = addr_q;
    exe_valid_d     = exe_valid_q;
    exe_addr_d      = exe_addr_q;
    exe_inst_d      = exe_inst_q;
    exe_imm_d       = exe_imm_q;
    exe_imm_valid_d = exe_imm_valid_q;

    case (state_q)
      S_REDIR: begin
        // A word taken during the redirect pulse belongs to the old stream.
        state_d = S_INST;
      end
      S_INST: begin
        if (consume) begin
          inst_d = fe_inst_i;
          addr_d = fe_addr_i;
          if (is_imm_form) begin
            state_d = S_IMM;
          end else begin
            exe_valid_d     = 1'b1;
            exe_addr_d      = fe_addr_i;
            exe_inst_d      = fe_inst_i;
            exe_imm_d       = 16'h0000;
            exe_imm_valid_d = 1'b0;
            state_d         = S_OUT;
          end
        end
      end
      S_IMM: begin
        if (consume) begin
`ifdef DECODE_JUMP_EN
          if (inst_q[15:12] == 4'hF) begin
            fe_pc_d = fe_inst_i;
            state_d = S_REDIR;
          end else begin
            exe_valid_d     = 1'b1;
            exe_addr_d      = addr_q;
            exe_inst_d      = inst_q;
            exe_imm_d       = fe_inst_i;
            exe_imm_valid_d = 1'b1;
            state_d         = S_OUT;
          end
`else
          exe_valid_d     = 1'b1;
          exe_addr_d      = addr_q;
          exe_inst_d      = inst_q;
          exe_imm_d       = fe_inst_i;
          exe_imm_valid_d = 1'b1;
          state_d         = S_OUT;
`endif
        end
      end
      S_OUT: begin
        if (exe_ready_i) begin
          exe_valid_d = 1'b0;
          state_d     = S_INST;
        end
      end
      default: state_d = S_REDIR;
    endcase

    // Handshake outputs follow the next state so they are registered with it.
    fe_valid_d = (state_d == S_REDIR);
    fe_ready_d = (state_d != S_OUT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_REDIR;
      fe_ready_q      <= 1'b1;
      fe_valid_q      <= 1'b1;
      fe_pc_q         <= RESET_PC;
      inst_q          <= 16'h0000;
      addr_q          <= 16'h0000;
      exe_valid_q     <= 1'b0;
      exe_addr_q      <= 16'h0000;
      exe_inst_q      <= 16'h0000;
      exe_imm_q       <= 16'h0000;
      exe_imm_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fe_ready_q      <= fe_ready_d;
      fe_valid_q      <= fe_valid_d;
      fe_pc_q         <= fe_pc_d;
      inst_q          <= inst_d;
      addr_q          <= addr_d;
      exe_valid_q     <= exe_valid_d;
      exe_addr_q      <= exe_addr_d;
      exe_inst_q      <= exe_inst_d;
      exe_imm_q       <= exe_imm_d;
      exe_imm_valid_q <= exe_imm_valid_d;
    end
  end

  assign fe_ready_o      = fe_ready_q;
  assign fe_valid_o      = fe_valid_q;
  assign fe_pc_o         = fe_pc_q;
  assign exe_valid_o     = exe_valid_q;
  assign exe_addr_o      = exe_addr_q;
  assign exe_opcode_o    = exe_inst_q[15:12];
  assign exe_src_reg_o   = exe_inst_q[11:8];
  assign exe_src_mode_o  = exe_inst_q[7:6];
  assign exe_dst_reg_o   = exe_inst_q[5:2];
  assign exe_dst_mode_o  = exe_inst_q[1:0];
  assign exe_imm_o       = exe_imm_q;
  assign exe_imm_valid_o = exe_imm_valid_q;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - self-checking bench for decode
module tb_decode;

  localparam logic [15:0] RPC = 16'h0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        fe_valid_i;
  logic        fe_ready_o;
  logic [15:0] fe_addr_i;
  logic [15:0] fe_inst_i;
  logic        fe_valid_o;
  logic [15:0] fe_pc_o;
  logic        exe_valid_o;
  logic        exe_ready_i;
  logic [15:0] exe_addr_o;
  logic [3:0]  exe_opcode_o;
  logic [3:0]  exe_src_reg_o;
  logic [1:0]  exe_src_mode_o;
  logic [3:0]  exe_dst_reg_o;
  logic [1:0]  exe_dst_mode_o;
  logic [15:0] exe_imm_o;
  logic        exe_imm_valid_o;

  decode #(.RESET_PC(RPC)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fe_valid_i     (fe_valid_i),
    .fe_ready_o     (fe_ready_o),
    .fe_addr_i      (fe_addr_i),
    .fe_inst_i      (fe_inst_i),
    .fe_valid_o     (fe_valid_o),
    .fe_pc_o        (fe_pc_o),
    .exe_valid_o    (exe_valid_o),
    .exe_ready_i    (exe_ready_i),
    .exe_addr_o     (exe_addr_o),
    .exe_opcode_o   (exe_opcode_o),
    .exe_src_reg_o  (exe_src_reg_o),
    .exe_src_mode_o (exe_src_mode_o),
    .exe_dst_reg_o  (exe_dst_reg_o),
    .exe_dst_mode_o (exe_dst_mode_o),
    .exe_imm_o      (exe_imm_o),
    .exe_imm_valid_o(exe_imm_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] addr;
    logic [3:0]  opcode;
    logic [3:0]  src_reg;
    logic [1:0]  src_mode;
    logic [3:0]  dst_reg;
    logic [1:0]  dst_mode;
    logic [15:0] imm;
    logic        imm_valid;
  } out_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        two;
    out_t        exp;
  } vec_t;

  vec_t vecs [6];
  out_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic out_t dut_out();
    return '{exe_addr_o, exe_opcode_o, exe_src_reg_o, exe_src_mode_o,
             exe_dst_reg_o, exe_dst_mode_o, exe_imm_o, exe_imm_valid_o};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk_i) begin
    if (!rst_i && exe_valid_o && exe_ready_i) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_exe: got %h with no expected instruction", dut_out());
      end else begin
        out_t e;
        e = sb_q.pop_front();
        if (dut_out() !== e) begin
          n_fail++;
          $display("FAIL exe_fields: got %h expected %h", dut_out(), e);
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] addr, input logic [15:0] inst);
    int waited = 0;
    @(negedge clk_i);
    while (!fe_ready_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    if (!fe_ready_o) chk("fe_ready_timeout", 64'(fe_ready_o), 64'd1);
    fe_valid_i = 1'b1;
    fe_addr_i  = addr;
    fe_inst_i  = inst;
    @(posedge clk_i);
    #1 fe_valid_i = 1'b0;
  endtask

  task automatic send_instr(input vec_t v);
    if (v.two) begin
      send_word(v.addr, v.w0);
      @(posedge clk_i);
      sb_q.push_back(v.exp);
      send_word(v.addr + 16'd1, v.w1);
    end else begin
      sb_q.push_back(v.exp);
      send_word(v.addr, v.w0);
    end
    @(negedge clk_i);
    chk("latency_exe_valid", 64'(exe_valid_o), 64'd1);
    chk("out_fe_ready_low", 64'(fe_ready_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //             addr      w0        w1        two    addr      opc   src   sm    dst   dm    imm       iv
    vecs[0] = '{16'h0010, 16'h1234, 16'h0000, 1'b0, '{16'h0010, 4'h1, 4'h2, 2'd0, 4'hD, 2'd0, 16'h0000, 1'b0}};
    vecs[1] = '{16'h0020, 16'h2FC4, 16'hBEEF, 1'b1, '{16'h0020, 4'h2, 4'hF, 2'd3, 4'h1, 2'd0, 16'hBEEF, 1'b1}};
    vecs[2] = '{16'h0030, 16'hA5B7, 16'h0000, 1'b0, '{16'h0030, 4'hA, 4'h5, 2'd2, 4'hD, 2'd3, 16'h0000, 1'b0}};
    vecs[3] = '{16'h0040, 16'h3EC9, 16'h0000, 1'b0, '{16'h0040, 4'h3, 4'hE, 2'd3, 4'h2, 2'd1, 16'h0000, 1'b0}};
    vecs[4] = '{16'h0050, 16'h4F89, 16'h0000, 1'b0, '{16'h0050, 4'h4, 4'hF, 2'd2, 4'h2, 2'd1, 16'h0000, 1'b0}};
    vecs[5] = '{16'h7FF0, 16'h7FFF, 16'h0000, 1'b1, '{16'h7FF0, 4'h7, 4'hF, 2'd3, 4'hF, 2'd3, 16'h0000, 1'b1}};

    rst_i       = 1'b1;
    fe_valid_i  = 1'b0;
    fe_addr_i   = 16'h0000;
    fe_inst_i   = 16'h0000;
    exe_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);

    // Reset held
    @(negedge clk_i);
    chk("rst_fe_valid", 64'(fe_valid_o), 64'd1);
    chk("rst_fe_pc", 64'(fe_pc_o), 64'(RPC));
    chk("rst_fe_ready", 64'(fe_ready_o), 64'd1);
    chk("rst_exe_valid", 64'(exe_valid_o), 64'd0);
    chk("rst_exe_fields", 64'(dut_out()), 64'd0);

    // Release; a word offered during the redirect pulse must be dropped
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    fe_valid_i = 1'b1;
    fe_addr_i  = 16'h0ABC;
    fe_inst_i  = 16'h1234;
    @(negedge clk_i);
    chk("redir_fe_valid", 64'(fe_valid_o), 64'd1);
    chk("redir_fe_pc", 64'(fe_pc_o), 64'(RPC));
    chk("redir_fe_ready", 64'(fe_ready_o), 64'd1);
    @(posedge clk_i);
    #1 fe_valid_i = 1'b0;
    @(negedge clk_i);
    chk("redir_pulse_end", 64'(fe_valid_o), 64'd0);
    chk("redir_word_dropped", 64'(exe_valid_o), 64'd0);

    // Table-driven instructions with EXECUTE always ready
    for (int i = 0; i < 6; i++) begin
      send_instr(vecs[i]);
      @(posedge clk_i);
    end

    // Back-pressure: hold outputs for 3 cycles with exe_ready_i low
    @(posedge clk_i);
    #1 exe_ready_i = 1'b0;
    send_instr(vecs[1]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_exe_valid", 64'(exe_valid_o), 64'd1);
      chk("stall_fe_ready", 64'(fe_ready_o), 64'd0);
      chk("stall_fields", 64'(dut_out()), 64'(vecs[1].exp));
    end
    @(posedge clk_i);
    #1 exe_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("release_exe_valid", 64'(exe_valid_o), 64'd0);
    chk("release_fe_ready", 64'(fe_ready_o), 64'd1);

    // Immediate jump FFC0 / 0200
`ifdef DECODE_JUMP_EN
    send_word(16'h0060, 16'hFFC0);
    @(posedge clk_i);
    send_word(16'h0061, 16'h0200);
    @(negedge clk_i);
    chk("jump_fe_valid", 64'(fe_valid_o), 64'd1);
    chk("jump_fe_pc", 64'(fe_pc_o), 64'h0200);
    chk("jump_exe_valid", 64'(exe_valid_o), 64'd0);
    chk("jump_fe_ready", 64'(fe_ready_o), 64'd1);
    fe_valid_i = 1'b1;
    fe_addr_i  = 16'h0062;
    fe_inst_i  = 16'h1234;
    @(posedge clk_i);
    #1 fe_valid_i = 1'b0;
    @(negedge clk_i);
    chk("jump_pulse_end", 64'(fe_valid_o), 64'd0);
    chk("jump_word_dropped", 64'(exe_valid_o), 64'd0);
`else
    v = '{16'h0060, 16'hFFC0, 16'h0200, 1'b1,
          '{16'h0060, 4'hF, 4'hF, 2'd3, 4'h0, 2'd0, 16'h0200, 1'b1}};
    send_instr(v);
    chk("nojump_fe_valid", 64'(fe_valid_o), 64'd0);
    @(posedge clk_i);
`endif

    // Reset while waiting for the immediate
    send_word(16'h0070, 16'h2FC4);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_fe_valid", 64'(fe_valid_o), 64'd1);
    chk("midrst_fe_pc", 64'(fe_pc_o), 64'(RPC));
    chk("midrst_exe_valid", 64'(exe_valid_o), 64'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_redir_valid", 64'(fe_valid_o), 64'd1);
    chk("midrst_redir_pc", 64'(fe_pc_o), 64'(RPC));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("midrst_no_exe", 64'(exe_valid_o), 64'd0);
      chk("midrst_no_redir", 64'(fe_valid_o), 64'd0);
    end

    // Recovery after the dropped instruction
    send_instr(vecs[2]);
    repeat (4) @(posedge clk_i);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the 16-bit CPU. It sits directly downstream of FETCH and consumes its instruction stream. It assembles one- or two-word instructions, splits them into fields and hands them to EXECUTE over a valid/ready handshake. It also sends PC redirects back to FETCH: once after reset, and on immediate jumps when jump handling is compiled in.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC sent to FETCH after reset.

Ports:
- Clocking and reset. One clock; reset is synchronous and active-high.
  - clk_i  in  1  system clock
  - rst_i  in  1  synchronous, active-high reset
- From FETCH:
  - fe_valid_i  in  1  instruction word valid
  - fe_ready_o  out  1  DECODE accepts the word
  - fe_addr_i  in  16  address of the word
  - fe_inst_i  in  16  instruction word
- To FETCH:
  - fe_valid_o  out  1  new PC valid (single-cycle pulse)
  - fe_pc_o  out  16  new PC
- To EXECUTE:
  - exe_valid_o  out  1  decoded instruction valid
  - exe_ready_i  in  1  EXECUTE accepts
  - exe_addr_o  out  16  address of the first word
  - exe_opcode_o  out  4  inst[15:12]
  - exe_src_reg_o  out  4  inst[11:8]
  - exe_src_mode_o  out  2  inst[7:6]
  - exe_dst_reg_o  out  4  inst[5:2]
  - exe_dst_mode_o  out  2  inst[1:0]
  - exe_imm_o  out  16  second word if present, else 0
  - exe_imm_valid_o  out  1  exe_imm_o is meaningful

## Operation
- A word is consumed on fe_valid_i && fe_ready_o.
- An instruction is immediate-form when src_mode==2'b11 and src_reg==4'hF. It then takes two words; the second word is the immediate.
- An immediate jump is opcode 4'hF in immediate form.
- States:
  - REDIR
    - fe_valid_o=1, fe_pc_o=target, fe_ready_o=1.
    - Any word consumed in this cycle is discarded.
    - Next state: INST.
  - INST
    - fe_ready_o=1.
    - On consume, latch fields and fe_addr_i.
    - If immediate form, go to IMM.
    - Otherwise load the EXECUTE outputs (exe_imm_valid_o=0, exe_imm_o=0) and go to OUT.
  - IMM
    - fe_ready_o=1.
    - On consume, latch the immediate.
    - If it is an immediate jump (with DECODE_JUMP_EN), set target=immediate and go to REDIR.
    - Otherwise load the EXECUTE outputs with exe_imm_valid_o=1 and go to OUT.
  - OUT
    - exe_valid_o=1, fe_ready_o=0.
    - Hold all exe_* outputs stable until exe_ready_i.
    - When exe_ready_i is seen, clear exe_valid_o and go to INST.
- fe_ready_o falls only in the cycle after a consume, i.e. on entering OUT. It is never low while FETCH has nothing presented, except while in OUT.
- Reset:
  - Taken from any state, including mid-instruction (IMM) or while holding OUT; the partial instruction is dropped.
  - Reset values: state=REDIR, target=RESET_PC, fe_valid_o=1, fe_pc_o=RESET_PC, fe_ready_o=1, exe_valid_o=0, exe_imm_valid_o=0, all other exe_* outputs 0.
  - While rst_i is held, the outputs stay at these values.

## Timing
- All outputs are registered.
- Latency:
  - Single-word instruction: exe_valid_o rises 1 cycle after its consume.
  - Two-word instruction: exe_valid_o rises 1 cycle after the immediate is consumed.
- Redirect:
  - fe_valid_o is high in the first cycle after rst_i falls.
  - After an immediate jump, fe_valid_o is high 1 cycle after the jump's immediate is consumed.
  - fe_valid_o lasts exactly 1 cycle.
- Throughput: at most one instruction per 2 cycles. This matches FETCH, which never presents words back-to-back.
- EXECUTE handshake: no combinational path from exe_ready_i to fe_ready_o. Release from OUT is registered.
- Stall bound: FETCH tolerates 4 cycles of stall. The block adds none beyond EXECUTE back-pressure plus 1 cycle.

## Configuration
- DECODE_JUMP_EN
  - Defined: immediate jumps are absorbed in DECODE. They go IMM -> REDIR with fe_pc_o=immediate and are never forwarded to EXECUTE.
  - Undefined: opcode 4'hF is treated like any other opcode and forwarded with its immediate. fe_valid_o then pulses only after reset.

## Test plan
- Reset release -> fe_valid_o=1, fe_pc_o=RESET_PC for exactly 1 cycle; fe_ready_o=1; exe_valid_o=0.
- Word 16'h1234 at addr 16'h0010, exe_ready_i=1 -> next cycle exe_valid_o=1, opcode 1, src_reg 2, src_mode 0, dst_reg 13, dst_mode 0, exe_addr_o=16'h0010, exe_imm_valid_o=0.
- Words 16'h2FC4 then 16'hBEEF -> single exe_valid_o with opcode 2, exe_imm_o=16'hBEEF, exe_imm_valid_o=1.
- Same instruction with exe_ready_i=0 for 3 cycles -> exe_* stable and fe_ready_o=0 throughout; exe_valid_o clears the cycle after exe_ready_i rises.
- DECODE_JUMP_EN, words 16'hFFC0 then 16'h0200 -> fe_valid_o pulse with fe_pc_o=16'h0200; exe_valid_o stays 0; a word consumed in the pulse cycle is discarded.
- rst_i asserted while in IMM -> no exe_valid_o; redirect to RESET_PC after release.
